// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the shared UART TX arbiter.
// master: arbiter side; slave: requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int data_len = 8
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*data_len-1:0] req_data;
  logic [NUM_REQ-1:0]          ack;
  logic [NUM_REQ-1:0]          grant;
  logic                        err;
  logic                        busy;
  logic                        tx_start;
  logic [data_len-1:0]         tx_data;
  logic                        tx_done;

  modport master (
    input  req, req_data, tx_done,
    output ack, grant, err, busy,
    output tx_start, tx_data
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, grant, err, busy,
    input  tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ clients.
// Ports: clk, rst (sync, active-high), bus (uart_tx_arbiter_if.master).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int data_len       = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_d;
  logic [PW-1:0]       ptr, ptr_d;
  logic [PW-1:0]       own, own_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic                tx_done_q;
  logic [NUM_REQ-1:0]  grant, grant_d;
  logic [NUM_REQ-1:0]  ack, ack_d;
  logic                err, err_d;
  logic                busy, busy_d;
  logic                tx_start, tx_start_d;
  logic [data_len-1:0] tx_data, tx_data_d;

  logic [data_len-1:0] lane [NUM_REQ];
  logic [PW-1:0]       win;
  logic [PW-1:0]       idx;
  logic                hit;
  logic                done_ev;
  logic [PW-1:0]       own_nxt;
  int                  sum;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = bus.req_data[g*data_len +: data_len];
  end

  // Only a fresh rising edge of tx_done counts as completion.
  assign done_ev = bus.tx_done && !tx_done_q;
  assign own_nxt = (own == LAST_IDX) ? '0 : own + PW'(1);

  // First requester at or after ptr, wrapping.
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    sum = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PW'(sum);
      if (!hit && bus.req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    own_d      = own;
    cnt_d      = cnt;
    grant_d    = '0;
    ack_d      = '0;
    err_d      = 1'b0;
    busy_d     = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = '0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          own_d        = win;
          grant_d[win] = 1'b1;
          tx_data_d    = lane[win];
          tx_start_d   = 1'b1;
          busy_d       = 1'b1;
          cnt_d        = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        cnt_d      = cnt + CW'(1);
        grant_d    = grant;
        tx_data_d  = tx_data;
        tx_start_d = 1'b1;
        busy_d     = 1'b1;
        // Completion takes priority over a same-cycle timeout.
        if (done_ev) begin
          ack_d[own] = 1'b1;
          grant_d    = '0;
          tx_data_d  = '0;
          tx_start_d = 1'b0;
          busy_d     = 1'b0;
          ptr_d      = own_nxt;
          state_d    = IDLE;
        end else if (TIMEOUT_CYCLES > 0 && cnt == CNT_LAST) begin
          err_d      = 1'b1;
          grant_d    = '0;
          tx_data_d  = '0;
          tx_start_d = 1'b0;
          busy_d     = 1'b0;
          ptr_d      = own_nxt;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      own       <= '0;
      cnt       <= '0;
      tx_done_q <= 1'b0;
      grant     <= '0;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      own       <= own_d;
      cnt       <= cnt_d;
      tx_done_q <= bus.tx_done;
      grant     <= grant_d;
      ack       <= ack_d;
      err       <= err_d;
      busy      <= busy_d;
      tx_start  <= tx_start_d;
      tx_data   <= tx_data_d;
    end
  end

  assign bus.grant    = grant;
  assign bus.ack      = ack;
  assign bus.err      = err;
  assign bus.busy     = busy;
  assign bus.tx_start = tx_start;
  assign bus.tx_data  = tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter.
// Expected grants come from a round-robin pointer model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   ptr = 0;
  int   cur = -1;
  int   ack_cnt [N];
  logic [7:0] dat [N];

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .data_len(8)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .data_len(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [31:0] oh(input int w);
    logic [31:0] v;
    v = 32'd1 << w;
    return v;
  endfunction

  task automatic load_data();
    bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
  endtask

  task automatic start(input string tag);
    cur = pick(bus.req, ptr);
    tick();
    if (cur < 0) begin
      chk({tag, ".grant"}, 32'(bus.grant), 0);
      chk({tag, ".tx_start"}, 32'(bus.tx_start), 0);
    end else begin
      chk({tag, ".grant"}, 32'(bus.grant), oh(cur));
      chk({tag, ".tx_start"}, 32'(bus.tx_start), 1);
      chk({tag, ".tx_data"}, 32'(bus.tx_data), 32'(dat[cur]));
      chk({tag, ".busy"}, 32'(bus.busy), 1);
    end
  endtask

  task automatic finish(input string tag, input int delay);
    repeat (delay) tick();
    chk({tag, ".hold_start"}, 32'(bus.tx_start), 1);
    chk({tag, ".hold_data"}, 32'(bus.tx_data), 32'(dat[cur]));
    chk({tag, ".no_ack"}, 32'(bus.ack), 0);
    bus.tx_done = 1'b1;
    tick();
    chk({tag, ".ack"}, 32'(bus.ack), oh(cur));
    chk({tag, ".grant0"}, 32'(bus.grant), 0);
    chk({tag, ".start0"}, 32'(bus.tx_start), 0);
    chk({tag, ".busy0"}, 32'(bus.busy), 0);
    chk({tag, ".err0"}, 32'(bus.err), 0);
    ack_cnt[cur]++;
    ptr = (cur + 1) % N;
    bus.tx_done = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b1;
    bus.req = '0;
    bus.tx_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      dat[i] = 8'h00;
      ack_cnt[i] = 0;
    end
    load_data();
    tick();
    tick();
    rst = 1'b0;
    chk("rst.grant", 32'(bus.grant), 0);
    chk("rst.ack", 32'(bus.ack), 0);
    chk("rst.err", 32'(bus.err), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.tx_start", 32'(bus.tx_start), 0);
    chk("rst.tx_data", 32'(bus.tx_data), 0);

    // Single request
    dat[2] = 8'hA5;
    load_data();
    bus.req = 4'b0100;
    start("single");
    finish("single", 20);
    bus.req = '0;
    tick();
    chk("single.ack_once", 32'(bus.ack), 0);
    chk("single.idle", 32'(bus.grant), 0);

    // Wrap from index 3 after serving 2
    bus.req = 4'b0011;
    start("wrap0");
    chk("wrap0.who", 32'(cur), 0);
    finish("wrap0", 3);
    start("wrap1");
    chk("wrap1.who", 32'(cur), 1);
    finish("wrap1", 3);
    bus.req = '0;
    tick();

    // Stale done high before grant
    bus.tx_done = 1'b1;
    tick();
    bus.req = 4'b0001;
    start("stale");
    repeat (5) tick();
    chk("stale.no_ack", 32'(bus.ack), 0);
    chk("stale.start", 32'(bus.tx_start), 1);
    bus.tx_done = 1'b0;
    tick();
    tick();
    chk("stale.no_ack2", 32'(bus.ack), 0);
    finish("stale", 0);
    bus.req = '0;
    tick();

    // Watchdog
    bus.req = 4'b0001;
    start("wd");
    repeat (49) tick();
    chk("wd.before_err", 32'(bus.err), 0);
    chk("wd.before_start", 32'(bus.tx_start), 1);
    tick();
    chk("wd.err", 32'(bus.err), 1);
    chk("wd.no_ack", 32'(bus.ack), 0);
    chk("wd.grant0", 32'(bus.grant), 0);
    chk("wd.start0", 32'(bus.tx_start), 0);
    ptr = (cur + 1) % N;
    start("wd.regrant");
    chk("wd.err_once", 32'(bus.err), 0);
    finish("wd.regrant", 5);
    bus.req = '0;
    tick();

    // Reset mid-frame
    bus.req = 4'b0100;
    start("rstmid");
    repeat (3) tick();
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    ptr = 0;
    chk("rstmid.grant", 32'(bus.grant), 0);
    chk("rstmid.start", 32'(bus.tx_start), 0);
    chk("rstmid.busy", 32'(bus.busy), 0);
    chk("rstmid.ack", 32'(bus.ack), 0);
    chk("rstmid.err", 32'(bus.err), 0);
    bus.req = 4'b1010;
    start("rstmid.first");
    chk("rstmid.first_who", 32'(cur), 1);
    finish("rstmid.first", 4);
    start("rstmid.second");
    finish("rstmid.second", 4);

    // Round robin with all requesting
    for (int i = 0; i < N; i++) begin
      dat[i] = 8'h10 + 8'(i);
      ack_cnt[i] = 0;
    end
    load_data();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      start("rr");
      chk("rr.order", 32'(cur), 32'(k % N));
      finish("rr", 2 + k);
      if (k == 3)
        for (int i = 0; i < N; i++)
          chk("rr.one_ack", 32'(ack_cnt[i]), 1);
    end
    bus.req = '0;
    tick();

    // Randomized requests against the pointer model
    for (int k = 0; k < 25; k++) begin
      r = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
      load_data();
      bus.req = r;
      start("rnd");
      if (cur >= 0) begin
        finish("rnd", int'($urandom_range(1, 20)));
        bus.req = '0;
        tick();
        chk("rnd.idle", 32'(bus.grant), 0);
      end
      bus.req = '0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter (tx_start / tx_data / tx_done handshake) among NUM_REQ requesters.
- Selects a requester, presents its byte, and holds tx_start until the transmitter reports completion via tx_done.
- Acknowledges the winning requester, then moves to the next requester. A watchdog aborts a grant when tx_done never arrives.
- Sits between client logic and the UART transmitter, in the clk domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- data_len, 8: frame data width; must match the transmitter.
- TIMEOUT_CYCLES, 0: clk cycles allowed in GRANT before abort; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester transmit request (level).
- req_data  input  NUM_REQ*data_len  requester i data at bits [i*data_len +: data_len].
- ack  output  NUM_REQ  one-cycle pulse to requester whose frame completed.
- grant  output  NUM_REQ  one-hot, current owner of the transmitter.
- err  output  1  one-cycle pulse on watchdog abort.
- busy  output  1  high while in GRANT.
- tx_start  output  1  request to transmitter.
- tx_data  output  data_len  data to transmitter.
- tx_done  input  1  transmitter completion flag (held high for the stop bit period).

Behaviour:
- All outputs are registered.
- Reset values: ack=0, grant=0, err=0, busy=0, tx_start=0, tx_data=0, state=IDLE, rr pointer=0, timeout counter=0, tx_done_q=0.
- tx_done_q registers tx_done every cycle. A done event is tx_done && !tx_done_q.
- IDLE:
  - If any req bit is set, pick the first set bit searching from index ptr upward, wrapping modulo NUM_REQ.
  - Next cycle: grant=onehot(w), tx_data=req_data[w], tx_start=1, busy=1, counter=0, state=GRANT.
  - No request: stay in IDLE, all outputs low.
  - Latency from req to tx_start is 1 cycle.
- GRANT:
  - Hold tx_start=1 and tx_data stable. Increment the counter.
  - A done event completes the grant. The done event is only recognised in GRANT. A tx_done already high on grant entry is not a new event; a fresh rising edge is required.
  - Next cycle after a done event: ack[w]=1 for exactly one cycle, grant=0, tx_start=0, busy=0, ptr=(w+1) mod NUM_REQ, state=IDLE.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without a done event: next cycle err=1 for one cycle, no ack, grant=0, tx_start=0, ptr=(w+1) mod NUM_REQ, state=IDLE.
  - If a done event and the timeout hit occur in the same cycle, the done event wins: ack, no err.
- The requester must hold req and its data until ack. req dropping during GRANT does not abort the frame; it completes and ack still pulses.
- IDLE after ack lasts one cycle. A pending request is then granted.
  - If the transmitter is still in its stop state, it chains directly into a new start frame.
  - Otherwise it starts from idle.
- Fairness: a requester holding req continuously waits for at most NUM_REQ-1 other frames.
- rst asserted mid-GRANT: next cycle all outputs and state are back to reset values. No ack or err is issued for the aborted frame.

Test Plan:
- Single request: req=4'b0100, req_data[2]=8'hA5. Expect grant=4'b0100 and tx_start=1 with tx_data=8'hA5 one cycle after req; tx_done rises 20 cycles later; next cycle ack=4'b0100 for exactly one cycle and tx_start=0.
- Round robin: req=4'b1111 held, data 8'h10/8'h11/8'h12/8'h13, model transmitter asserts tx_done. Grant order is 0,1,2,3,0 and tx_data follows 10,11,12,13,10; each requester gets exactly one ack per rotation.
- Wrap from last index: ptr=3 after granting requester 2, req=4'b0011. Next grant is requester 0, then 1.
- Watchdog: TIMEOUT_CYCLES=50, tx_done tied 0, req=4'b0001. err pulses once 50 cycles after grant, no ack, grant=0; with req still high, requester 0 is re-granted next.
- Stale done: tx_done already 1 when grant begins. No ack until tx_done falls and rises again.
- Reset mid-frame: sync rst for 1 cycle during GRANT. Next cycle grant=0, tx_start=0, busy=0, ptr=0, no ack/err; afterwards req=4'b1010 grants requester 1 first.
